dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/dmem_arb_starve_ctr.sv | 29 ++
 rtl/dmem_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int WAIT_CNT_W = 4;

  // Who owns the read data coming back from memory on the next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DEV  = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Counts consecutive conflict losses of the device; at_max forces a device win.
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int WAIT_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic conflict,
  input  logic dev_win,
  output logic at_max
);

  logic [WAIT_CNT_W-1:0] wait_cnt_reg;

  // Holds whenever there is neither a device grant nor a CPU-won conflict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_reg <= '0;
    end else if (dev_win) begin
      wait_cnt_reg <= '0;
    end else if (conflict) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  assign at_max = (wait_cnt_reg == WAIT_CNT_W'(WAIT_MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/device arbiter in front of a single-port synchronous data memory.
// Optional grant/conflict statistics counters: define DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int Dbits    = 32,
  parameter int Abits    = 32,
  parameter int WAIT_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_wr,
  input  logic [Abits-1:0] cpu_addr,
  input  logic [Dbits-1:0] cpu_wdata,
  output logic             cpu_stall,
  output logic [Dbits-1:0] cpu_rdata,
  input  logic             dev_req,
  input  logic             dev_wr,
  input  logic [Abits-1:0] dev_addr,
  input  logic [Dbits-1:0] dev_wdata,
  output logic             dev_gnt,
  output logic [Dbits-1:0] dev_rdata,
  output logic             dev_rvalid,
`ifdef DMEM_ARB_STATS_EN
  output logic [31:0]      stat_cpu_grants,
  output logic [31:0]      stat_dev_grants,
  output logic [31:0]      stat_conflicts,
`endif
  output logic             mem_wr,
  output logic [Abits-1:0] mem_addr,
  output logic [Dbits-1:0] mem_wdata,
  input  logic [Dbits-1:0] mem_rdata
);

  logic   conflict;
  logic   at_max;
  logic   cpu_gnt;
  owner_t owner_reg, owner_next;
  logic [Dbits-1:0] cpu_rdata_reg;
  logic [Dbits-1:0] dev_rdata_reg;

  assign conflict = cpu_req & dev_req;

  // Grants are masked while reset is asserted so no command reaches memory.
  assign dev_gnt   = reset & dev_req & (~cpu_req | at_max);
  assign cpu_gnt   = reset & cpu_req & ~dev_gnt;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  dmem_arb_starve_ctr #(
    .WAIT_MAX(WAIT_MAX)
  ) u_starve_ctr (
    .clk     (clk),
    .reset   (reset),
    .conflict(conflict),
    .dev_win (dev_gnt),
    .at_max  (at_max)
  );

  // Idle cycles keep the CPU address/data on the bus.
  assign mem_wr    = (cpu_gnt & cpu_wr) | (dev_gnt & dev_wr);
  assign mem_addr  = dev_gnt ? dev_addr  : cpu_addr;
  assign mem_wdata = dev_gnt ? dev_wdata : cpu_wdata;

  always_comb begin
    owner_next = OWN_NONE;
    if (dev_gnt && !dev_wr) begin
      owner_next = OWN_DEV;
    end else if (cpu_gnt && !cpu_wr) begin
      owner_next = OWN_CPU;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_reg     <= OWN_NONE;
      cpu_rdata_reg <= '0;
      dev_rdata_reg <= '0;
    end else begin
      owner_reg <= owner_next;
      if (owner_reg == OWN_CPU) cpu_rdata_reg <= mem_rdata;
      if (owner_reg == OWN_DEV) dev_rdata_reg <= mem_rdata;
    end
  end

  // Read data is forwarded combinationally in the return cycle, then held.
  assign cpu_rdata  = (owner_reg == OWN_CPU) ? mem_rdata : cpu_rdata_reg;
  assign dev_rdata  = (owner_reg == OWN_DEV) ? mem_rdata : dev_rdata_reg;
  assign dev_rvalid = (owner_reg == OWN_DEV);

`ifdef DMEM_ARB_STATS_EN
  logic [2:0] stat_evt;
  assign stat_evt = {conflict & reset, dev_gnt, cpu_gnt};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    logic [31:0] cnt_reg;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_reg <= '0;
      end else if (stat_evt[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end

  assign stat_cpu_grants = g_stat[0].cnt_reg;
  assign stat_dev_grants = g_stat[1].cnt_reg;
  assign stat_conflicts  = g_stat[2].cnt_reg;
`endif

endmodule
